// File: rtl/snake_body_controller.sv
// snake_body_controller: owns the snake head/body position state and the game-state FSM.
// Ports:
//   clk, nrst                      clock and asynchronous active-low reset
//   start                          level: IDLE->RUN, DEAD/WIN->IDLE (reinit)
//   move_tick                      one-clk pulse per game step
//   direction                      requested heading (00 up, 01 down, 10 left, 11 right)
//   bad_collision                  registered wall/border/self hit
//   good_collision(2)              registered apple hits
//   head_x, head_y                 current head cell
//   body_x, body_y                 body segments, index 0 nearest the head; unused entries are (0,0)
//   length                         number of valid body segments
//   heading                        direction applied on the last move
//   apple_eaten                    one-clk pulse after an EVAL that saw an apple hit
//   playing, game_over, win        state decodes
module snake_body_controller #(
  parameter int          MAX_LENGTH  = 30,
  parameter int          INIT_LENGTH = 3,
  parameter logic [3:0]  INIT_X      = 4'd5,
  parameter logic [3:0]  INIT_Y      = 4'd5,
  parameter int          LEN_W       = $clog2(MAX_LENGTH+1)
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        start,
  input  logic                        move_tick,
  input  logic [1:0]                  direction,
  input  logic                        bad_collision,
  input  logic                        good_collision,
  input  logic                        good_collision2,
  output logic [3:0]                  head_x,
  output logic [3:0]                  head_y,
  output logic [MAX_LENGTH-1:0][3:0]  body_x,
  output logic [MAX_LENGTH-1:0][3:0]  body_y,
  output logic [LEN_W-1:0]            length,
  output logic [1:0]                  heading,
  output logic                        apple_eaten,
  output logic                        playing,
  output logic                        game_over,
  output logic                        win
);
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_SETTLE, S_EVAL, S_DEAD, S_WIN} state_t;
  localparam logic [LEN_W-1:0] MAX_L  = LEN_W'(MAX_LENGTH);
  localparam logic [LEN_W-1:0] INIT_L = LEN_W'(INIT_LENGTH);
  state_t                       r_state, w_next;
  logic [3:0]                   r_hx, r_hy, w_hx, w_hy;
  logic [MAX_LENGTH-1:0][3:0]   r_bx, r_by, w_bx, w_by, w_shx, w_shy, w_ibx, w_iby;
  logic [LEN_W-1:0]             r_len, w_len;
  logic [1:0]                   r_heading, w_dir, r_grow, w_g, w_gp;
  logic [2:0]                   w_gsum;
  logic                         r_apple, w_grow, w_move, w_reinit;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = start ? S_RUN : S_IDLE;
      S_RUN:    w_next = move_tick ? S_SETTLE : S_RUN;
      S_SETTLE: w_next = S_EVAL;
      S_EVAL:   w_next = bad_collision ? S_DEAD : (r_len == MAX_L ? S_WIN : S_RUN);
      S_DEAD:   w_next = start ? S_IDLE : S_DEAD;
      S_WIN:    w_next = start ? S_IDLE : S_WIN;
      default:  w_next = S_IDLE;
    endcase
  end
  assign w_move   = r_state == S_RUN && move_tick;
  assign w_reinit = (r_state == S_DEAD || r_state == S_WIN) && start;
  // reversal iff directions differ only in bit 0 (00<->01, 10<->11)
  assign w_dir  = (direction ^ r_heading) == 2'b01 ? r_heading : direction;
  assign w_hx   = w_dir == 2'b10 ? r_hx - 4'd1 : w_dir == 2'b11 ? r_hx + 4'd1 : r_hx;
  assign w_hy   = w_dir == 2'b00 ? r_hy - 4'd1 : w_dir == 2'b01 ? r_hy + 4'd1 : r_hy;
  assign w_grow = r_grow != 2'd0 && r_len < MAX_L;
  assign w_len  = r_len + LEN_W'(w_grow);
  assign w_shx  = {r_bx[MAX_LENGTH-2:0], r_hx};
  assign w_shy  = {r_by[MAX_LENGTH-2:0], r_hy};
  assign w_g    = {1'b0, good_collision} + {1'b0, good_collision2};
  assign w_gsum = {1'b0, r_grow} + {1'b0, w_g};
  assign w_gp   = w_gsum > 3'd3 ? 2'd3 : w_gsum[1:0];
  // entries at or beyond the new length are forced to the (0,0) border cell
  always_comb begin
    w_bx  = '0;
    w_by  = '0;
    w_ibx = '0;
    w_iby = '0;
    for (int i = 0; i < MAX_LENGTH; i++) begin
      w_bx[i]  = LEN_W'(i) < w_len ? w_shx[i] : 4'd0;
      w_by[i]  = LEN_W'(i) < w_len ? w_shy[i] : 4'd0;
      w_ibx[i] = i < INIT_LENGTH ? 4'(int'(INIT_X) - 1 - i) : 4'd0;
      w_iby[i] = i < INIT_LENGTH ? INIT_Y : 4'd0;
    end
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      r_hx      <= INIT_X;
      r_hy      <= INIT_Y;
      r_bx      <= w_ibx;
      r_by      <= w_iby;
      r_len     <= INIT_L;
      r_heading <= 2'b11;
      r_grow    <= 2'd0;
      r_apple   <= 1'b0;
    end else if (w_reinit) begin
      r_hx      <= INIT_X;
      r_hy      <= INIT_Y;
      r_bx      <= w_ibx;
      r_by      <= w_iby;
      r_len     <= INIT_L;
      r_heading <= 2'b11;
      r_grow    <= 2'd0;
      r_apple   <= 1'b0;
    end else begin
      r_apple <= r_state == S_EVAL && !bad_collision && w_g != 2'd0;
      if (w_move) begin
        r_hx      <= w_hx;
        r_hy      <= w_hy;
        r_heading <= w_dir;
        r_bx      <= w_bx;
        r_by      <= w_by;
        r_len     <= w_len;
        r_grow    <= r_grow - {1'b0, w_grow};
      end
      if (r_state == S_EVAL && !bad_collision) r_grow <= w_gp;
    end
  assign head_x      = r_hx;
  assign head_y      = r_hy;
  assign body_x      = r_bx;
  assign body_y      = r_by;
  assign length      = r_len;
  assign heading     = r_heading;
  assign apple_eaten = r_apple;
  assign playing     = r_state == S_RUN || r_state == S_SETTLE || r_state == S_EVAL;
  assign game_over   = r_state == S_DEAD;
  assign win         = r_state == S_WIN;
endmodule

// File: tb/tb_snake_body_controller.sv
// tb_snake_body_controller: directed self-checking bench for snake_body_controller (default and MAX_LENGTH=5 builds).
module tb_snake_body_controller;
  logic clk = 1'b0, nrst = 1'b0, start = 1'b0, move_tick = 1'b0;
  logic [1:0] direction = 2'b11;
  logic bad_collision = 1'b0, good_collision = 1'b0, good_collision2 = 1'b0;
  logic [3:0] head_x, head_y, h5_x, h5_y;
  logic [29:0][3:0] body_x, body_y;
  logic [4:0][3:0] b5_x, b5_y;
  logic [4:0] length;
  logic [2:0] len5;
  logic [1:0] heading, hd5;
  logic apple_eaten, playing, game_over, win, ap5, pl5, go5, win5;
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  snake_body_controller dut (
    .clk(clk), .nrst(nrst), .start(start), .move_tick(move_tick), .direction(direction),
    .bad_collision(bad_collision), .good_collision(good_collision), .good_collision2(good_collision2),
    .head_x(head_x), .head_y(head_y), .body_x(body_x), .body_y(body_y), .length(length),
    .heading(heading), .apple_eaten(apple_eaten), .playing(playing), .game_over(game_over), .win(win)
  );
  snake_body_controller #(.MAX_LENGTH(5)) dut5 (
    .clk(clk), .nrst(nrst), .start(start), .move_tick(move_tick), .direction(direction),
    .bad_collision(bad_collision), .good_collision(good_collision), .good_collision2(good_collision2),
    .head_x(h5_x), .head_y(h5_y), .body_x(b5_x), .body_y(b5_y), .length(len5),
    .heading(hd5), .apple_eaten(ap5), .playing(pl5), .game_over(go5), .win(win5)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic move(input logic [1:0] d);
    move_tick = 1'b1;
    direction = d;
    step();
    move_tick = 1'b0;
    step();
    step();
  endtask
  initial begin
    step();
    step();
    chk("rst_len", 32'(length), 3);
    chk("rst_hx", 32'(head_x), 5);
    chk("rst_hy", 32'(head_y), 5);
    chk("rst_heading", 32'(heading), 3);
    chk("rst_playing", 32'(playing), 0);
    nrst = 1'b1;
    step();
    chk("idle_tick_ignored", 32'(playing), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("run_playing", 32'(playing), 1);
    chk("init_b0x", 32'(body_x[0]), 4);
    chk("init_b0y", 32'(body_y[0]), 5);
    chk("init_b2x", 32'(body_x[2]), 2);
    chk("init_b3x", 32'(body_x[3]), 0);
    chk("init_b3y", 32'(body_y[3]), 0);
    good_collision = 1'b1;
    move(2'b10);
    good_collision = 1'b0;
    chk("rev_hx", 32'(head_x), 6);
    chk("rev_heading", 32'(heading), 3);
    chk("rev_b0x", 32'(body_x[0]), 5);
    chk("rev_b2x", 32'(body_x[2]), 3);
    chk("rev_b3x", 32'(body_x[3]), 0);
    chk("eat_pulse", 32'(apple_eaten), 1);
    chk("eat_len", 32'(length), 3);
    step();
    chk("eat_pulse_end", 32'(apple_eaten), 0);
    move(2'b11);
    chk("grow_len", 32'(length), 4);
    chk("grow_tail_b3x", 32'(body_x[3]), 3);
    chk("grow_b0x", 32'(body_x[0]), 6);
    good_collision = 1'b1;
    good_collision2 = 1'b1;
    move(2'b00);
    good_collision = 1'b0;
    good_collision2 = 1'b0;
    chk("up_hy", 32'(head_y), 4);
    chk("both_pulse", 32'(apple_eaten), 1);
    chk("both_len", 32'(length), 4);
    move(2'b00);
    chk("both_grow1", 32'(length), 5);
    move(2'b01);
    chk("both_grow2", 32'(length), 6);
    chk("rev_up_hy", 32'(head_y), 2);
    chk("rev_up_heading", 32'(heading), 0);
    chk("rev_up_b0y", 32'(body_y[0]), 3);
    move(2'b10);
    chk("left_hx", 32'(head_x), 6);
    chk("nogrow_len", 32'(length), 6);
    bad_collision = 1'b1;
    good_collision = 1'b1;
    move(2'b10);
    bad_collision = 1'b0;
    good_collision = 1'b0;
    chk("dead_over", 32'(game_over), 1);
    chk("dead_no_apple", 32'(apple_eaten), 0);
    chk("dead_playing", 32'(playing), 0);
    move_tick = 1'b1;
    step();
    step();
    move_tick = 1'b0;
    chk("dead_frozen_hx", 32'(head_x), 5);
    chk("dead_frozen_len", 32'(length), 6);
    start = 1'b1;
    step();
    chk("reinit_hx", 32'(head_x), 5);
    chk("reinit_hy", 32'(head_y), 5);
    chk("reinit_len", 32'(length), 3);
    chk("reinit_b3x", 32'(body_x[3]), 0);
    chk("reinit_heading", 32'(heading), 3);
    chk("reinit_over", 32'(game_over), 0);
    step();
    start = 1'b0;
    chk("relaunch_playing", 32'(playing), 1);
    move_tick = 1'b1;
    direction = 2'b11;
    step();
    step();
    step();
    move_tick = 1'b0;
    chk("settle_eval_tick_ignored", 32'(head_x), 6);
    move_tick = 1'b1;
    step();
    move_tick = 1'b0;
    chk("settle_hx", 32'(head_x), 7);
    nrst = 1'b0;
    #1;
    chk("async_rst_hx", 32'(head_x), 5);
    chk("async_rst_len", 32'(length), 3);
    chk("async_rst_playing", 32'(playing), 0);
    step();
    nrst = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    good_collision = 1'b1;
    move(2'b11);
    chk("m5_len1", 32'(len5), 3);
    move(2'b11);
    chk("m5_len2", 32'(len5), 4);
    move(2'b11);
    good_collision = 1'b0;
    chk("m5_len3", 32'(len5), 5);
    chk("m5_win", 32'(win5), 1);
    chk("m5_apple_at_win", 32'(ap5), 1);
    chk("m5_playing", 32'(pl5), 0);
    chk("m5_b4x", 32'(b5_x[4]), 3);
    move_tick = 1'b1;
    step();
    step();
    move_tick = 1'b0;
    chk("m5_len_capped", 32'(len5), 5);
    chk("m5_hx_frozen", 32'(h5_x), 8);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
